cpu_ir_decode_alu: RTL and testbench

Instruction register, main decoder and ALU of the single-cycle MIPS-subset CPU datapath. It latches the fetched 32-bit instruction word and decodes it combinationally into register-file addresses, immediates and control strobes. It then computes the ALU result and zero flag from the register-file operands. It sits between the program-counter/instruction-memory fetch stage and the register file, data memory and write-back mux.

---
 rtl/cpu_ir_decode_alu.sv | 167 ++++++++++++++++
 tb/tb_cpu_ir_decode_alu.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cpu_ir_decode_alu.sv
// Instruction register, main decoder and ALU for the single-cycle MIPS-subset datapath.
// IR is the only state; decode, operand select and ALU are combinational from IR and the register-file reads.
module cpu_ir_decode_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_en,
  input  logic [31:0] instr_in,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] inst,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  wr_addr,
  output logic [15:0] imm16,
  output logic [25:0] imm26,
  output logic [3:0]  alu_ctr,
  output logic        reg_dst,
  output logic        reg_wrt,
  output logic        mem_read,
  output logic        mem_wrt,
  output logic        mem_reg,
  output logic        alu_src,
  output logic        branch,
  output logic        jump,
  output logic [31:0] alu_out,
  output logic        zf
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        sign_ext;
  logic [31:0] imm_ext;
  logic [31:0] op_a;
  logic [31:0] op_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      inst <= 32'h0;
    else if (ir_en)
      inst <= instr_in;
  end

  assign opcode  = inst[31:26];
  assign funct   = inst[5:0];
  assign rs      = inst[25:21];
  assign rt      = inst[20:16];
  assign rd      = inst[15:11];
  assign imm16   = inst[15:0];
  assign imm26   = inst[25:0];
  assign wr_addr = reg_dst ? rd : rt;

  // Unrecognised opcodes/functs fall through the defaults and behave as NOPs.
  always_comb begin
    alu_ctr  = ALU_ADD;
    reg_dst  = 1'b0;
    reg_wrt  = 1'b0;
    mem_read = 1'b0;
    mem_wrt  = 1'b0;
    mem_reg  = 1'b0;
    alu_src  = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    sign_ext = 1'b1;
    case (opcode)
      6'b000000: begin
        reg_dst = 1'b1;
        reg_wrt = 1'b1;
        case (funct)
          6'b100000, 6'b100001: alu_ctr = ALU_ADD;
          6'b100010, 6'b100011: alu_ctr = ALU_SUB;
          6'b100100:            alu_ctr = ALU_AND;
          6'b100101:            alu_ctr = ALU_OR;
          6'b100110:            alu_ctr = ALU_XOR;
          6'b100111:            alu_ctr = ALU_NOR;
          6'b101010:            alu_ctr = ALU_SLT;
          6'b101011:            alu_ctr = ALU_SLTU;
          default: begin
            reg_dst = 1'b0;
            reg_wrt = 1'b0;
          end
        endcase
      end
      6'b001000, 6'b001001: begin
        alu_src = 1'b1;
        reg_wrt = 1'b1;
      end
      6'b001010: begin
        alu_ctr = ALU_SLT;
        alu_src = 1'b1;
        reg_wrt = 1'b1;
      end
      6'b001100: begin
        alu_ctr  = ALU_AND;
        alu_src  = 1'b1;
        reg_wrt  = 1'b1;
        sign_ext = 1'b0;
      end
      6'b001101: begin
        alu_ctr  = ALU_OR;
        alu_src  = 1'b1;
        reg_wrt  = 1'b1;
        sign_ext = 1'b0;
      end
      6'b001110: begin
        alu_ctr  = ALU_XOR;
        alu_src  = 1'b1;
        reg_wrt  = 1'b1;
        sign_ext = 1'b0;
      end
      6'b001111: begin
        alu_ctr = ALU_LUI;
        alu_src = 1'b1;
        reg_wrt = 1'b1;
      end
      6'b100011: begin
        alu_src  = 1'b1;
        mem_read = 1'b1;
        mem_reg  = 1'b1;
        reg_wrt  = 1'b1;
      end
      6'b101011: begin
        alu_src = 1'b1;
        mem_wrt = 1'b1;
      end
      6'b000100: begin
        alu_ctr = ALU_SUB;
        branch  = 1'b1;
      end
      6'b000010: jump = 1'b1;
      default: ;
    endcase
  end

  assign imm_ext = sign_ext ? {{16{inst[15]}}, inst[15:0]} : {16'h0000, inst[15:0]};
  assign op_a    = rs_data;
  assign op_b    = alu_src ? imm_ext : rt_data;

  always_comb begin
    alu_out = 32'h0;
    case (alu_ctr)
      ALU_AND:  alu_out = op_a & op_b;
      ALU_OR:   alu_out = op_a | op_b;
      ALU_ADD:  alu_out = op_a + op_b;
      ALU_XOR:  alu_out = op_a ^ op_b;
      ALU_SUB:  alu_out = op_a - op_b;
      ALU_SLT:  alu_out = ($signed(op_a) < $signed(op_b)) ? 32'h1 : 32'h0;
      ALU_SLTU: alu_out = (op_a < op_b) ? 32'h1 : 32'h0;
      ALU_LUI:  alu_out = {op_b[15:0], 16'h0000};
      ALU_NOR:  alu_out = ~(op_a | op_b);
      default:  alu_out = 32'h0;
    endcase
  end

  assign zf = ~|alu_out;

endmodule

// File: tb/tb_cpu_ir_decode_alu.sv
// Directed, table-driven bench for cpu_ir_decode_alu plus hand-written reset/hold sequences.
module tb_cpu_ir_decode_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ir_en = 1'b0;
  logic [31:0] instr_in = 32'h0;
  logic [31:0] rs_data = 32'h0;
  logic [31:0] rt_data = 32'h0;
  logic [31:0] inst;
  logic [4:0]  rs, rt, rd, wr_addr;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [3:0]  alu_ctr;
  logic        reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src, branch, jump;
  logic [31:0] alu_out;
  logic        zf;
  logic [7:0]  ctrl;

  int passed = 0;
  int total  = 0;

  cpu_ir_decode_alu dut (
    .clk(clk), .rst(rst), .ir_en(ir_en), .instr_in(instr_in),
    .rs_data(rs_data), .rt_data(rt_data), .inst(inst),
    .rs(rs), .rt(rt), .rd(rd), .wr_addr(wr_addr),
    .imm16(imm16), .imm26(imm26), .alu_ctr(alu_ctr),
    .reg_dst(reg_dst), .reg_wrt(reg_wrt), .mem_read(mem_read), .mem_wrt(mem_wrt),
    .mem_reg(mem_reg), .alu_src(alu_src), .branch(branch), .jump(jump),
    .alu_out(alu_out), .zf(zf)
  );

  always #5 clk = ~clk;

  // Control bits in order: reg_dst reg_wrt mem_read mem_wrt mem_reg alu_src branch jump
  assign ctrl = {reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src, branch, jump};

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_zf;
    logic [7:0]  exp_ctrl;
    logic [3:0]  exp_ctr;
    logic [4:0]  exp_wr;
  } vec_t;

  vec_t vecs[21];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Load a word into IR on the next rising edge, then present the operands.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    instr_in = instr;
    ir_en    = 1'b1;
    @(posedge clk);
    #1;
    ir_en   = 1'b0;
    rs_data = a;
    rt_data = b;
    #1;
  endtask

  initial begin
    vecs[0]  = '{"add",      32'h012A4020, 32'd5,        32'd7,        32'd12,       1'b0, 8'b11000000, 4'b0010, 5'd8};
    vecs[1]  = '{"addi_m1",  32'h2129FFFF, 32'd1,        32'd0,        32'd0,        1'b1, 8'b01000100, 4'b0010, 5'd9};
    vecs[2]  = '{"ori_ffff", 32'h3409FFFF, 32'd0,        32'd0,        32'h0000FFFF, 1'b0, 8'b01000100, 4'b0001, 5'd9};
    vecs[3]  = '{"lw",       32'h8D090004, 32'h100,      32'd0,        32'h104,      1'b0, 8'b01101100, 4'b0010, 5'd9};
    vecs[4]  = '{"sw",       32'hAD090004, 32'h100,      32'd0,        32'h104,      1'b0, 8'b00010100, 4'b0010, 5'd9};
    vecs[5]  = '{"beq_eq",   32'h11090003, 32'h55,       32'h55,       32'h0,        1'b1, 8'b00000010, 4'b0110, 5'd9};
    vecs[6]  = '{"beq_ne",   32'h11090003, 32'h55,       32'h56,       32'hFFFFFFFF, 1'b0, 8'b00000010, 4'b0110, 5'd9};
    vecs[7]  = '{"j",        32'h08000010, 32'd3,        32'd4,        32'd7,        1'b0, 8'b00000001, 4'b0010, 5'd0};
    vecs[8]  = '{"unknown",  32'hFC000000, 32'd2,        32'd3,        32'd5,        1'b0, 8'b00000000, 4'b0010, 5'd0};
    vecs[9]  = '{"slt",      32'h012A402A, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 8'b11000000, 4'b0111, 5'd8};
    vecs[10] = '{"sltu",     32'h012A402B, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 8'b11000000, 4'b1000, 5'd8};
    vecs[11] = '{"sub",      32'h012A4022, 32'd10,       32'd3,        32'd7,        1'b0, 8'b11000000, 4'b0110, 5'd8};
    vecs[12] = '{"and",      32'h012A4024, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 8'b11000000, 4'b0000, 5'd8};
    vecs[13] = '{"nor",      32'h012A4027, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 8'b11000000, 4'b1100, 5'd8};
    vecs[14] = '{"xor",      32'h012A4026, 32'hFF,       32'h0F,       32'hF0,       1'b0, 8'b11000000, 4'b0011, 5'd8};
    vecs[15] = '{"lui",      32'h3C091234, 32'h5,        32'd0,        32'h12340000, 1'b0, 8'b01000100, 4'b1001, 5'd9};
    vecs[16] = '{"andi_zx",  32'h31098000, 32'hFFFFFFFF, 32'd0,        32'h00008000, 1'b0, 8'b01000100, 4'b0000, 5'd9};
    vecs[17] = '{"slti_m1",  32'h2909FFFF, 32'd0,        32'd0,        32'd0,        1'b1, 8'b01000100, 4'b0111, 5'd9};
    vecs[18] = '{"zero_nop", 32'h00000000, 32'd1,        32'd2,        32'd3,        1'b0, 8'b00000000, 4'b0010, 5'd0};
    vecs[19] = '{"bad_fn",   32'h012A4008, 32'd1,        32'd1,        32'd2,        1'b0, 8'b00000000, 4'b0010, 5'd10};
    vecs[20] = '{"xori_zx",  32'h3909FFFF, 32'd0,        32'd0,        32'h0000FFFF, 1'b0, 8'b01000100, 4'b0011, 5'd9};

    // Reset state
    rst = 1'b1;
    #2;
    checkOutput("rst_inst", inst, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Load add, then assert reset mid-cycle: IR must clear without a clock edge
    applyStimulus(32'h012A4020, 32'd5, 32'd0);
    checkOutput("pre_rst_inst", inst, 32'h012A4020);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_inst", inst, 32'h0);
    checkOutput("async_rst_ctrl", {24'h0, ctrl}, 32'h0);
    checkOutput("async_rst_aluctr", {28'h0, alu_ctr}, 32'h2);
    checkOutput("async_rst_fields", {imm26, rd, 1'b0}, 32'h0);
    checkOutput("async_rst_aluout", alu_out, 32'd5);

    // Reset dominates ir_en across an edge
    instr_in = 32'h8D090004;
    ir_en    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_priority", inst, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("first_load", inst, 32'h8D090004);
    ir_en = 1'b0;

    // Table-driven decode/ALU vectors
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].a, vecs[i].b);
      checkOutput({vecs[i].name, "_inst"}, inst, vecs[i].instr);
      checkOutput({vecs[i].name, "_out"}, alu_out, vecs[i].exp_out);
      checkOutput({vecs[i].name, "_zf"}, {31'h0, zf}, {31'h0, vecs[i].exp_zf});
      checkOutput({vecs[i].name, "_ctrl"}, {24'h0, ctrl}, {24'h0, vecs[i].exp_ctrl});
      checkOutput({vecs[i].name, "_aluctr"}, {28'h0, alu_ctr}, {28'h0, vecs[i].exp_ctr});
      checkOutput({vecs[i].name, "_wraddr"}, {27'h0, wr_addr}, {27'h0, vecs[i].exp_wr});
    end

    // Field extraction
    applyStimulus(32'h012A4020, 32'd0, 32'd0);
    checkOutput("rs_field", {27'h0, rs}, 32'd9);
    checkOutput("rt_field", {27'h0, rt}, 32'd10);
    checkOutput("rd_field", {27'h0, rd}, 32'd8);
    checkOutput("imm16_field", {16'h0, imm16}, 32'h4020);
    applyStimulus(32'h08000010, 32'd0, 32'd0);
    checkOutput("j_imm26", {6'h0, imm26}, 32'h10);

    // ir_en=0 holds IR while instr_in changes
    applyStimulus(32'h012A4020, 32'd5, 32'd7);
    instr_in = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("hold_inst", inst, 32'h012A4020);
    checkOutput("hold_aluout", alu_out, 32'd12);

    // Operand changes propagate without a clock edge
    @(negedge clk);
    rt_data = 32'hFFFFFFFB;
    #1;
    checkOutput("comb_aluout", alu_out, 32'h0);
    checkOutput("comb_zf", {31'h0, zf}, 32'h1);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
